// File: rtl/alu_cmd_sender_if.sv
// Command / UART byte / response bundle between alu_cmd_sender and its neighbours.
// The slave modport is the sender's view; master is the command/UART side.
interface alu_cmd_sender_if #(
    parameter int NB_DATA   = 8,
    parameter int NB_OPCODE = 6
);
    logic                 i_req_valid;
    logic                 o_req_ready;
    logic [NB_DATA-1:0]   i_first_operator;
    logic [NB_DATA-1:0]   i_second_operator;
    logic [NB_OPCODE-1:0] i_opcode;

    logic                 o_tx_start;
    logic [NB_DATA-1:0]   o_tx_data;
    logic                 i_tx_done;

    logic                 i_rx_data_valid;
    logic [NB_DATA-1:0]   i_rx_data;

    logic                 o_resp_valid;
    logic                 i_resp_ready;
    logic [NB_DATA-1:0]   o_result;
    logic                 o_resp_error;
    logic                 o_busy;

    modport slave (
        input  i_req_valid, i_first_operator, i_second_operator, i_opcode,
        input  i_tx_done, i_rx_data_valid, i_rx_data, i_resp_ready,
        output o_req_ready, o_tx_start, o_tx_data, o_resp_valid, o_result,
        output o_resp_error, o_busy
    );

    modport master (
        output i_req_valid, i_first_operator, i_second_operator, i_opcode,
        output i_tx_done, i_rx_data_valid, i_rx_data, i_resp_ready,
        input  o_req_ready, o_tx_start, o_tx_data, o_resp_valid, o_result,
        input  o_resp_error, o_busy
    );
endinterface

// File: rtl/alu_cmd_sender.sv
// Serialises an ALU command (A, B, opcode) over a UART TX byte port and returns the result byte.
// Define ALU_CMD_SENDER_TIMEOUT_EN to bound the wait for the result byte (timeout -> o_resp_error).
module alu_cmd_sender #(
    parameter int NB_DATA        = 8,
    parameter int NB_OPCODE      = 6,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic               i_clock,
    input  logic               i_reset,
    alu_cmd_sender_if.slave    bus
);

    if (NB_OPCODE > NB_DATA || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("alu_cmd_sender: invalid parameter combination");
    end

    typedef enum logic [2:0] {IDLE, TX_START, TX_WAIT, RX_WAIT, RESP} state_t;

    state_t               state;
    logic [1:0]           idx;
    logic [NB_DATA-1:0]   a_q;
    logic [NB_DATA-1:0]   b_q;
    logic [NB_OPCODE-1:0] op_q;

`ifdef ALU_CMD_SENDER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt;
`else
    assign bus.o_resp_error = 1'b0;
`endif

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state            <= IDLE;
            idx              <= '0;
            a_q              <= '0;
            b_q              <= '0;
            op_q             <= '0;
            bus.o_req_ready  <= 1'b1;
            bus.o_busy       <= 1'b0;
            bus.o_tx_start   <= 1'b0;
            bus.o_tx_data    <= '0;
            bus.o_resp_valid <= 1'b0;
            bus.o_result     <= '0;
`ifdef ALU_CMD_SENDER_TIMEOUT_EN
            cnt              <= '0;
            bus.o_resp_error <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_req_valid && bus.o_req_ready) begin
                        a_q             <= bus.i_first_operator;
                        b_q             <= bus.i_second_operator;
                        op_q            <= bus.i_opcode;
                        idx             <= '0;
                        bus.o_req_ready <= 1'b0;
                        bus.o_busy      <= 1'b1;
                        // Byte 0 goes straight from the inputs so the start pulse lands next cycle.
                        bus.o_tx_start  <= 1'b1;
                        bus.o_tx_data   <= bus.i_first_operator;
                        state           <= TX_START;
                    end
                end
                TX_START: begin
                    bus.o_tx_start <= 1'b0;
                    state          <= TX_WAIT;
                end
                TX_WAIT: begin
                    if (bus.i_tx_done) begin
                        if (idx == 2'd2) begin
`ifdef ALU_CMD_SENDER_TIMEOUT_EN
                            cnt   <= '0;
`endif
                            state <= RX_WAIT;
                        end else begin
                            idx            <= idx + 2'd1;
                            bus.o_tx_start <= 1'b1;
                            bus.o_tx_data  <= (idx == 2'd0) ? b_q : NB_DATA'(op_q);
                            state          <= TX_START;
                        end
                    end
                end
                RX_WAIT: begin
                    if (bus.i_rx_data_valid) begin
                        bus.o_result     <= bus.i_rx_data;
                        bus.o_resp_valid <= 1'b1;
`ifdef ALU_CMD_SENDER_TIMEOUT_EN
                        bus.o_resp_error <= 1'b0;
`endif
                        state            <= RESP;
`ifdef ALU_CMD_SENDER_TIMEOUT_EN
                    end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        bus.o_result     <= '0;
                        bus.o_resp_error <= 1'b1;
                        bus.o_resp_valid <= 1'b1;
                        state            <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
`endif
                    end
                end
                RESP: begin
                    // Ready rises only after the consume edge, so no same-cycle re-accept.
                    if (bus.i_resp_ready) begin
                        bus.o_resp_valid <= 1'b0;
                        bus.o_busy       <= 1'b0;
                        bus.o_req_ready  <= 1'b1;
                        state            <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sender.sv
// Randomised bench for alu_cmd_sender: a per-command reference (byte queue + expected response)
// checks TX order/stability, stale-RX rejection, response hold, reset abort and the optional timeout.
module tb_alu_cmd_sender;
    localparam int NBD = 8;
    localparam int NBO = 6;
    localparam int TO  = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_cmd_sender_if #(.NB_DATA(NBD), .NB_OPCODE(NBO)) bus();

    alu_cmd_sender #(.NB_DATA(NBD), .NB_OPCODE(NBO), .TIMEOUT_CYCLES(TO)) dut (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int n_starts = 0;

    always @(posedge clk) if (bus.o_tx_start === 1'b1) n_starts++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; with jitter the request side keeps hammering new fields while busy.
    task automatic nxt(input bit jit);
        @(negedge clk);
        if (jit) begin
            bus.i_req_valid       = 1'b1;
            bus.i_first_operator  = NBD'($urandom);
            bus.i_second_operator = NBD'($urandom);
            bus.i_opcode          = NBO'($urandom);
        end
    endtask

    // One full command; called and returns at a falling edge with the DUT idle.
    task automatic run_cmd(input logic [NBD-1:0] a, input logic [NBD-1:0] b,
                           input logic [NBO-1:0] op, input int done_dly, input int rx_dly,
                           input bit stale, input bit do_to, input int hold, input bit jit,
                           input logic [NBD-1:0] rx_byte);
        logic [NBD-1:0] exp_q[$];
        logic [NBD-1:0] d;
        logic [NBD-1:0] exp_res;
        logic           exp_err;
        bit             stable, early, held;
        int             w;
        exp_q = '{a, b, NBD'(op)};

        chk("req_ready_idle", 32'(bus.o_req_ready), 1);
        bus.i_req_valid       = 1'b1;
        bus.i_first_operator  = a;
        bus.i_second_operator = b;
        bus.i_opcode          = op;
        nxt(jit);
        if (!jit) bus.i_req_valid = 1'b0;
        chk("req_ready_busy", 32'(bus.o_req_ready), 0);
        chk("busy_set", 32'(bus.o_busy), 1);

        for (int k = 0; k < 3; k++) begin
            w = 0;
            while (bus.o_tx_start !== 1'b1 && w < 20) begin nxt(jit); w++; end
            if (bus.o_tx_start !== 1'b1) begin
                chk("tx_start_timeout", 0, 1);
                bus.i_req_valid = 1'b0;
                return;
            end
            d = bus.o_tx_data;
            chk($sformatf("tx_byte%0d", k), 32'(d), 32'(exp_q[k]));
            stable = 1;
            for (int c = 0; c < done_dly; c++) begin
                nxt(jit);
                if (c == 0) chk("tx_start_pulse", 32'(bus.o_tx_start), 0);
                if (stale && c == 1) begin
                    bus.i_rx_data_valid = 1'b1;
                    bus.i_rx_data       = 8'hAA;
                end else begin
                    bus.i_rx_data_valid = 1'b0;
                end
                if (bus.o_tx_data !== d) stable = 0;
            end
            bus.i_tx_done = 1'b1;
            nxt(jit);
            bus.i_tx_done       = 1'b0;
            bus.i_rx_data_valid = 1'b0;
            chk("tx_data_stable", 32'(stable), 1);
        end
        bus.i_req_valid = 1'b0;

        if (do_to) begin
            w = 0;
            while (bus.o_resp_valid !== 1'b1 && w < TO + 10) begin @(negedge clk); w++; end
            chk("timeout_latency", 32'(w), 32'(TO));
            exp_res = '0;
            exp_err = 1'b1;
        end else begin
            early = 0;
            for (int c = 0; c < rx_dly; c++) begin
                @(negedge clk);
                if (bus.o_resp_valid !== 1'b0) early = 1;
            end
            chk("no_early_resp", 32'(early), 0);
            bus.i_rx_data_valid = 1'b1;
            bus.i_rx_data       = rx_byte;
            @(negedge clk);
            bus.i_rx_data_valid = 1'b0;
            exp_res = rx_byte;
            exp_err = 1'b0;
        end

        chk("resp_valid", 32'(bus.o_resp_valid), 1);
        chk("result", 32'(bus.o_result), 32'(exp_res));
        chk("resp_error", 32'(bus.o_resp_error), 32'(exp_err));
        held = 1;
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            if (bus.o_resp_valid !== 1'b1 || bus.o_result !== exp_res ||
                bus.o_resp_error !== exp_err || bus.o_req_ready !== 1'b0) held = 0;
        end
        chk("resp_held", 32'(held), 1);
        bus.i_resp_ready = 1'b1;
        chk("req_ready_consume", 32'(bus.o_req_ready), 0);
        @(negedge clk);
        bus.i_resp_ready = 1'b0;
        chk("resp_cleared", 32'(bus.o_resp_valid), 0);
        chk("req_ready_after", 32'(bus.o_req_ready), 1);
        chk("busy_clear", 32'(bus.o_busy), 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        bit quiet;
        bus.i_req_valid = 0; bus.i_first_operator = 0; bus.i_second_operator = 0; bus.i_opcode = 0;
        bus.i_tx_done = 0; bus.i_rx_data_valid = 0; bus.i_rx_data = 0; bus.i_resp_ready = 0;

        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(bus.o_req_ready), 1);
        chk("rst_busy", 32'(bus.o_busy), 0);
        chk("rst_tx_start", 32'(bus.o_tx_start), 0);
        chk("rst_tx_data", 32'(bus.o_tx_data), 0);
        chk("rst_resp_valid", 32'(bus.o_resp_valid), 0);
        chk("rst_result", 32'(bus.o_result), 0);
        chk("rst_resp_error", 32'(bus.o_resp_error), 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_cmd(8'h05, 8'h03, 6'h20, 4, 2, 0, 0, 0, 0, 8'h08);     // basic command
        run_cmd(8'h12, 8'h34, 6'h3F, 4, 3, 1, 0, 0, 0, 8'h11);     // stale 0xAA during TX_WAIT
        run_cmd(8'hFF, 8'h00, 6'h01, 2, 0, 0, 0, 10, 0, 8'h5A);    // response backpressure
        run_cmd(8'hA5, 8'h5A, 6'h2A, 3, 1, 0, 0, 1, 1, 8'hC3);     // fields churn while busy
`ifdef ALU_CMD_SENDER_TIMEOUT_EN
        run_cmd(8'h21, 8'h43, 6'h15, 4, 0, 0, 1, 2, 0, 8'h00);     // no result byte -> timeout
`else
        run_cmd(8'h21, 8'h43, 6'h15, 4, 40, 0, 0, 2, 0, 8'h77);    // waits indefinitely
`endif
        run_cmd(8'h66, 8'h77, 6'h08, 2, TO - 1, 0, 0, 0, 0, 8'h99); // byte on the expiry cycle

        // Reset during the second byte's TX_WAIT.
        bus.i_req_valid = 1'b1; bus.i_first_operator = 8'h31;
        bus.i_second_operator = 8'h42; bus.i_opcode = 6'h13;
        @(negedge clk);
        bus.i_req_valid = 1'b0;
        repeat (2) @(negedge clk);
        bus.i_tx_done = 1'b1;
        @(negedge clk);
        bus.i_tx_done = 1'b0;
        chk("rst_test_byte1", 32'(bus.o_tx_data), 32'h42);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(bus.o_busy), 0);
        chk("abort_req_ready", 32'(bus.o_req_ready), 1);
        chk("abort_tx_data", 32'(bus.o_tx_data), 0);
        chk("abort_result", 32'(bus.o_result), 0);
        rst_n = 1'b1;
        s0 = n_starts;
        quiet = 1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            bus.i_tx_done       = 1'($urandom);
            bus.i_rx_data_valid = 1'($urandom);
            bus.i_rx_data       = NBD'($urandom);
            if (bus.o_resp_valid !== 1'b0) quiet = 0;
        end
        @(negedge clk);
        bus.i_tx_done = 1'b0;
        bus.i_rx_data_valid = 1'b0;
        chk("abort_no_resp", 32'(quiet), 1);
        chk("abort_no_start", 32'(n_starts - s0), 0);
        run_cmd(8'h9C, 8'h4E, 6'h07, 3, 2, 0, 0, 0, 0, 8'h3B);

        for (int i = 0; i < 10; i++) begin
            run_cmd(NBD'($urandom), NBD'($urandom), NBO'($urandom),
                    int'($urandom_range(2, 6)), int'($urandom_range(0, 12)),
                    1'($urandom), 1'b0, int'($urandom_range(0, 4)), 1'($urandom),
                    NBD'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
        $finish;
    end
endmodule
